// File: rtl/mem_arbiter_rr_if.sv
// Decoupled valid/ready channel bundle: N parallel lanes carrying W-bit payloads.
// The arbiter uses one instance per side: master requests, master responses,
// slave request and slave response.
interface mem_arbiter_rr_if #(
  parameter int N = 1,
  parameter int W = 32
);
  logic [N-1:0]        valid;
  logic [N-1:0]        ready;
  logic [N-1:0][W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/mem_arbiter_rr.sv
// N-master -> 1-slave memory arbiter with fixed or rotating priority, a
// per-master in-flight limit, and in-order response routing through a
// fallthrough tag FIFO. Both paths are combinational pass-through.
// Optional feature macro: MEM_ARB_PERF_EN adds per-master grant/stall counters.
module mem_arbiter_rr #(
  parameter int CNT             = 4,
  parameter int QUEUE_DEPTH     = 4,
  parameter int ROUND_ROBIN     = 1,
  parameter int MAX_OUTSTANDING = 2,
  parameter int REQ_W           = 32,
  parameter int RESP_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  mem_arbiter_rr_if.slave  master_req,
  mem_arbiter_rr_if.master master_resp,
  mem_arbiter_rr_if.master slave_req,
  mem_arbiter_rr_if.slave  slave_resp
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [CNT-1:0][31:0] grant_cnt,
  output logic [CNT-1:0][31:0] stall_cnt
`endif
);
  localparam int IDX_W = (CNT > 1) ? $clog2(CNT) : 1;
  localparam int CW    = $clog2(QUEUE_DEPTH + 1);
  localparam int PW    = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam logic [CW-1:0]    DEPTH_C   = CW'(QUEUE_DEPTH);
  localparam logic [CW-1:0]    MAX_OUT_C = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0]    LAST_C    = PW'(QUEUE_DEPTH - 1);
  localparam logic [IDX_W-1:0] PTR_RST_C = IDX_W'(CNT - 1);

  logic [IDX_W-1:0] ptr;
  logic [CW-1:0]    out_cnt [CNT];
  logic [IDX_W-1:0] tags [QUEUE_DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic [CNT-1:0]   elig;
  logic [IDX_W-1:0] sel;
  logic [IDX_W-1:0] scan_idx;
  logic [IDX_W-1:0] stored_head;
  logic [IDX_W-1:0] head;
  logic any_elig, fifo_empty, fifo_full, fifo_valid;
  logic req_fire_empty, resp_fire_full, req_valid, req_fire, resp_ready, resp_fire;

  // Mask masters that have no request or have reached their in-flight limit.
  always_comb begin
    elig = '0;
    for (int i = 0; i < CNT; i++) begin
      if (MAX_OUTSTANDING == 0) elig[i] = master_req.valid[i];
      else                      elig[i] = master_req.valid[i] && (out_cnt[i] < MAX_OUT_C);
    end
  end

  // Pick the winner; scanning backwards lets the highest-priority hit land last.
  always_comb begin
    sel      = '0;
    scan_idx = '0;
    if (ROUND_ROBIN != 0) begin
      for (int k = CNT; k >= 1; k--) begin
        scan_idx = IDX_W'((int'(ptr) + k) % CNT);
        sel      = elig[scan_idx] ? scan_idx : sel;
      end
    end else begin
      for (int i = CNT - 1; i >= 0; i--) begin
        scan_idx = IDX_W'(i);
        sel      = elig[scan_idx] ? scan_idx : sel;
      end
    end
  end

  // Full/empty terms are split out so the request and response paths never
  // feed each other combinationally: when empty only a bypass can provide a
  // head, when full only a pop can make room.
  assign any_elig       = |elig;
  assign fifo_empty     = (count == '0);
  assign fifo_full      = (count == DEPTH_C);
  assign stored_head    = tags[rd_ptr];
  assign req_fire_empty = fifo_empty && any_elig && slave_req.ready[0] && !rst;
  assign resp_fire_full = fifo_full && slave_resp.valid[0] && master_resp.ready[stored_head] && !rst;
  assign req_valid      = any_elig && (!fifo_full || resp_fire_full) && !rst;
  assign req_fire       = req_valid && slave_req.ready[0];
  assign fifo_valid     = !fifo_empty || req_fire_empty;
  assign head           = fifo_empty ? sel : stored_head;
  assign resp_ready     = fifo_valid && master_resp.ready[head] && !rst;
  assign resp_fire      = resp_ready && slave_resp.valid[0];

  // Drive both handshake sides from the arbitration and FIFO head decisions.
  always_comb begin
    slave_req.valid   = req_valid;
    slave_req.data    = '0;
    slave_req.data[0] = rst ? '0 : master_req.data[sel];
    slave_resp.ready  = resp_ready;
    master_req.ready  = '0;
    master_resp.valid = '0;
    master_resp.data  = '0;
    for (int i = 0; i < CNT; i++) begin
      master_req.ready[i]  = req_fire && (sel == IDX_W'(i));
      master_resp.valid[i] = slave_resp.valid[0] && fifo_valid && (head == IDX_W'(i));
      master_resp.data[i]  = rst ? '0 : slave_resp.data[0];
    end
  end

  // Rotate priority so the last granted master becomes lowest priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           ptr <= PTR_RST_C;
    else if (req_fire) ptr <= sel;
    else               ptr <= ptr;
  end

  // Tag FIFO holding the owner of each in-flight request, oldest at rd_ptr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) tags[i] <= '0;
    end else begin
      if (req_fire) begin
        tags[wr_ptr] <= sel;
        wr_ptr       <= (wr_ptr == LAST_C) ? '0 : wr_ptr + 1'b1;
      end
      if (resp_fire) rd_ptr <= (rd_ptr == LAST_C) ? '0 : rd_ptr + 1'b1;
      case ({req_fire, resp_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Per-master in-flight counters; bounded by the FIFO so they cannot wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CNT; i++) out_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < CNT; i++) begin
        case ({req_fire && (sel == IDX_W'(i)), resp_fire && (head == IDX_W'(i))})
          2'b10:   out_cnt[i] <= out_cnt[i] + 1'b1;
          2'b01:   out_cnt[i] <= out_cnt[i] - 1'b1;
          default: out_cnt[i] <= out_cnt[i];
        endcase
      end
    end
  end

`ifdef MEM_ARB_PERF_EN
  // Count accepted requests and back-pressured request cycles per master.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < CNT; i++) begin
        if (req_fire && (sel == IDX_W'(i))) grant_cnt[i] <= grant_cnt[i] + 32'd1;
        if (master_req.valid[i] && !(req_fire && (sel == IDX_W'(i))))
          stall_cnt[i] <= stall_cnt[i] + 32'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Scoreboard bench for mem_arbiter_rr: stimulus pushes expected grants and
// responses into queues; negedge monitors pop and compare on every fire.
module tb_mem_arbiter_rr;
  localparam int CNT = 4;
  localparam int W   = 32;

  typedef struct {
    int          idx;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  logic [31:0] grant_q[$];
  logic [31:0] b_grant_q[$];
  exp_t        resp_q[$];

  always #5 clk = ~clk;

  // Main instance: rotating priority, limit 2, depth 4.
  mem_arbiter_rr_if #(.N(CNT), .W(W)) mreq_if ();
  mem_arbiter_rr_if #(.N(CNT), .W(W)) mresp_if ();
  mem_arbiter_rr_if #(.N(1),   .W(W)) sreq_if ();
  mem_arbiter_rr_if #(.N(1),   .W(W)) sresp_if ();
  // Second instance: fixed priority, unlimited.
  mem_arbiter_rr_if #(.N(CNT), .W(W)) b_mreq_if ();
  mem_arbiter_rr_if #(.N(CNT), .W(W)) b_mresp_if ();
  mem_arbiter_rr_if #(.N(1),   .W(W)) b_sreq_if ();
  mem_arbiter_rr_if #(.N(1),   .W(W)) b_sresp_if ();

`ifdef MEM_ARB_PERF_EN
  logic [CNT-1:0][31:0] grant_cnt, stall_cnt, b_grant_cnt, b_stall_cnt;
`endif

  mem_arbiter_rr #(.CNT(CNT), .QUEUE_DEPTH(4), .ROUND_ROBIN(1), .MAX_OUTSTANDING(2),
                   .REQ_W(W), .RESP_W(W)) dut (
    .clk(clk), .rst(rst),
    .master_req(mreq_if), .master_resp(mresp_if),
    .slave_req(sreq_if), .slave_resp(sresp_if)
`ifdef MEM_ARB_PERF_EN
    , .grant_cnt(grant_cnt), .stall_cnt(stall_cnt)
`endif
  );

  mem_arbiter_rr #(.CNT(CNT), .QUEUE_DEPTH(2), .ROUND_ROBIN(0), .MAX_OUTSTANDING(0),
                   .REQ_W(W), .RESP_W(W)) dut_b (
    .clk(clk), .rst(rst),
    .master_req(b_mreq_if), .master_resp(b_mresp_if),
    .slave_req(b_sreq_if), .slave_resp(b_sresp_if)
`ifdef MEM_ARB_PERF_EN
    , .grant_cnt(b_grant_cnt), .stall_cnt(b_stall_cnt)
`endif
  );

  function automatic logic [31:0] md(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_resp(input int idx, input logic [31:0] d);
    exp_t e;
    e.idx  = idx;
    e.data = d;
    resp_q.push_back(e);
  endtask

  // Monitor of the main instance: every request or response fire pops one expectation.
  always @(negedge clk) begin : mon_main
    logic [31:0] eg;
    exp_t        er;
    if (sreq_if.valid[0] && sreq_if.ready[0]) begin
      if (grant_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL grant_unexpected got=%h expected=none", sreq_if.data[0]);
      end else begin
        eg = grant_q.pop_front();
        check("grant_data", sreq_if.data[0], eg);
      end
    end
    for (int i = 0; i < CNT; i++) begin
      if (mresp_if.valid[i] && mresp_if.ready[i]) begin
        if (resp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL resp_unexpected got=port%0d expected=none", i);
        end else begin
          er = resp_q.pop_front();
          check("resp_port", 32'(i), 32'(er.idx));
          check("resp_data", mresp_if.data[i], er.data);
        end
      end
    end
  end

  // Monitor of the fixed-priority instance: request grants only.
  always @(negedge clk) begin : mon_b
    logic [31:0] eg;
    if (b_sreq_if.valid[0] && b_sreq_if.ready[0]) begin
      if (b_grant_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL b_grant_unexpected got=%h expected=none", b_sreq_if.data[0]);
      end else begin
        eg = b_grant_q.pop_front();
        check("b_grant_data", b_sreq_if.data[0], eg);
      end
    end
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < CNT; i++) begin
      mreq_if.data[i]   = md(i);
      b_mreq_if.data[i] = md(i);
    end
    mreq_if.valid      = 4'hF;
    mresp_if.ready     = 4'hF;
    sreq_if.ready      = 1'b1;
    sresp_if.valid     = 1'b1;
    sresp_if.data[0]   = 32'hDEAD_0000;
    b_mreq_if.valid    = 4'h0;
    b_mresp_if.ready   = 4'hF;
    b_sreq_if.ready    = 1'b1;
    b_sresp_if.valid   = 1'b1;
    b_sresp_if.data[0] = 32'hBBBB_0000;

    // Reset with live inputs: every output must stay low.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_sreq_valid", 32'(sreq_if.valid), 32'd0);
    check("rst_mreq_ready", 32'(mreq_if.ready), 32'd0);
    check("rst_sresp_ready", 32'(sresp_if.ready), 32'd0);
    check("rst_mresp_valid", 32'(mresp_if.valid), 32'd0);
    check("rst_sreq_data", sreq_if.data[0], 32'd0);
`ifdef MEM_ARB_PERF_EN
    check("rst_grant_cnt0", grant_cnt[0], 32'd0);
`endif
    step();
    rst = 1'b0;

    // All four masters for 8 cycles, same-cycle responses: 0,1,2,3,0,1,2,3.
    for (int k = 0; k < 8; k++) begin
      sresp_if.data[0] = 32'hA000_0000 + 32'(k);
      grant_q.push_back(md(k % 4));
      push_resp(k % 4, 32'hA000_0000 + 32'(k));
      step();
    end
    mreq_if.valid  = 4'h0;
    sresp_if.valid = 1'b0;

    // Fixed priority: master 1 beats master 3 until it drops.
    b_mreq_if.valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      b_grant_q.push_back(md(1));
      if (k == 0) begin
        @(negedge clk);
        check("fp_m3_ready", 32'(b_mreq_if.ready[3]), 32'd0);
      end
      step();
    end
    b_mreq_if.valid = 4'b1000;
    b_grant_q.push_back(md(3));
    step();
    b_mreq_if.valid = 4'b0000;

    // Outstanding limit: master 0 alone, responses withheld.
    mreq_if.valid = 4'b0001;
    grant_q.push_back(md(0)); step();
    grant_q.push_back(md(0)); step();
    @(negedge clk);
    check("limit_ready0", 32'(mreq_if.ready[0]), 32'd0);
    check("limit_sreq_valid", 32'(sreq_if.valid), 32'd0);
    step();
    sresp_if.valid   = 1'b1;
    sresp_if.data[0] = 32'hB000_0000;
    push_resp(0, 32'hB000_0000);
    @(negedge clk);
    check("limit_resp_ready", 32'(sresp_if.ready), 32'd1);
    check("limit_ready0_during_resp", 32'(mreq_if.ready[0]), 32'd0);
    step();
    sresp_if.valid = 1'b0;
    grant_q.push_back(md(0));
    step();
    @(negedge clk);
    check("limit_ready0_again", 32'(mreq_if.ready[0]), 32'd0);
    step();

    // FIFO full: masters 1,2 fill it, then pop and push in one cycle.
    mreq_if.valid = 4'b0111;
    grant_q.push_back(md(1)); step();
    grant_q.push_back(md(2)); step();
    @(negedge clk);
    check("full_sreq_valid", 32'(sreq_if.valid), 32'd0);
    step();
    sresp_if.valid   = 1'b1;
    sresp_if.data[0] = 32'hC000_0000;
    push_resp(0, 32'hC000_0000);
    grant_q.push_back(md(1));
    @(negedge clk);
    check("full_pop_sreq_valid", 32'(sreq_if.valid), 32'd1);
    check("full_pop_resp_ready", 32'(sresp_if.ready), 32'd1);
    step();
    mreq_if.valid = 4'b0000;
    for (int j = 0; j < 4; j++) begin
      sresp_if.data[0] = 32'hC000_0001 + 32'(j);
      push_resp((j == 2) ? 2 : ((j == 0) ? 0 : 1), 32'hC000_0001 + 32'(j));
      step();
    end
    @(negedge clk);
    check("empty_resp_stall", 32'(sresp_if.ready), 32'd0);
    check("empty_mresp_valid", 32'(mresp_if.valid), 32'd0);
    step();
    sresp_if.valid = 1'b0;

    // Same-cycle response to a master that is not ready: stalled, then delivered.
    mreq_if.valid    = 4'b0100;
    mresp_if.ready   = 4'b1011;
    sresp_if.valid   = 1'b1;
    sresp_if.data[0] = 32'hD000_0000;
    grant_q.push_back(md(2));
    @(negedge clk);
    check("bypass_mresp_valid2", 32'(mresp_if.valid[2]), 32'd1);
    check("bypass_resp_stall", 32'(sresp_if.ready), 32'd0);
    step();
    mreq_if.valid  = 4'b0000;
    mresp_if.ready = 4'hF;
    push_resp(2, 32'hD000_0000);
    step();
    sresp_if.valid = 1'b0;

    // Reset mid-burst with three in flight (ptr=2 -> grants 3,0,1).
    mreq_if.valid = 4'hF;
    grant_q.push_back(md(3)); step();
    grant_q.push_back(md(0)); step();
    grant_q.push_back(md(1)); step();
    rst              = 1'b1;
    sresp_if.valid   = 1'b1;
    sresp_if.data[0] = 32'hE000_0000;
    @(negedge clk);
    check("midrst_sreq_valid", 32'(sreq_if.valid), 32'd0);
    check("midrst_mreq_ready", 32'(mreq_if.ready), 32'd0);
    check("midrst_mresp_valid", 32'(mresp_if.valid), 32'd0);
    check("midrst_sresp_ready", 32'(sresp_if.ready), 32'd0);
    step();
    rst            = 1'b0;
    sresp_if.valid = 1'b0;
    grant_q.push_back(md(0));
    @(negedge clk);
    check("post_rst_sreq_valid", 32'(sreq_if.valid), 32'd1);
`ifdef MEM_ARB_PERF_EN
    for (int i = 0; i < CNT; i++) begin
      check("post_rst_grant_cnt", grant_cnt[i], 32'd0);
      check("post_rst_stall_cnt", stall_cnt[i], 32'd0);
    end
`endif
    step();
    grant_q.push_back(md(1));
    step();
    mreq_if.valid    = 4'h0;
    sresp_if.valid   = 1'b1;
    sresp_if.data[0] = 32'hF000_0000;
    push_resp(0, 32'hF000_0000);
    step();
    sresp_if.data[0] = 32'hF000_0001;
    push_resp(1, 32'hF000_0001);
    step();
    sresp_if.valid = 1'b0;
    repeat (2) step();

    check("grant_q_left", 32'(grant_q.size()), 32'd0);
    check("resp_q_left", 32'(resp_q.size()), 32'd0);
    check("b_grant_q_left", 32'(b_grant_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
